// File: rtl/apb_mem_slave_pkg.sv
// apb_mem_slave_pkg: shared FSM state codes and address-check helper for the APB memory slave
package apb_mem_slave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   // An access errors when enabled and the offset is outside the window or not word aligned.
   function automatic logic addr_err(
      input logic [15:0] off,
      input logic [15:0] size,
      input logic [15:0] mask,
      input logic        en
   );
      return en & ((off >= size) | ((off & mask) != 16'd0));
   endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// apb_mem_slave_if: APB bus bundle between one initiator PSEL line and one completer
interface apb_mem_slave_if #(
   parameter int P_DWIDTH = 32
);
   localparam int P_STRB = P_DWIDTH / 8;

   logic                PSEL;
   logic                PENABLE;
   logic                PWRITE;
   logic [31:0]         PADDR;
   logic [P_DWIDTH-1:0] PWDATA;
   logic [P_STRB-1:0]   PSTRB;
   logic [2:0]          PPROT;
   logic [P_DWIDTH-1:0] PRDATA;
   logic                PREADY;
   logic                PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_mem_slave_ram.sv
// apb_mem_slave_ram: single-port synchronous RAM with per-byte write enables and registered read data
module apb_mem_slave_ram #(
   parameter int  P_DWIDTH = 32,
   parameter int  P_DEPTH  = 4,
   localparam int P_STRB   = P_DWIDTH / 8,
   localparam int AW       = P_DEPTH > 1 ? $clog2(P_DEPTH) : 1
) (
   input  logic                PCLK,
   input  logic                we,
   input  logic [P_STRB-1:0]   be,
   input  logic [AW-1:0]       addr,
   input  logic [P_DWIDTH-1:0] wdata,
   output logic [P_DWIDTH-1:0] rdata
);

   logic [P_DWIDTH-1:0] mem [P_DEPTH];

   // Byte-lane writes and a read of the old word at the same edge; contents survive reset.
   always_ff @(posedge PCLK) begin
      for (int i = 0; i < P_STRB; i++)
         if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
   end

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB3/APB4 completer with a byte-enabled memory window, programmable wait states and PSLVERR
module apb_mem_slave
   import apb_mem_slave_pkg::*;
#(
   parameter int          P_DWIDTH = 32,
   parameter logic [15:0] P_SIZE   = 16'h0010,
   parameter int          P_WAIT   = 0,
   parameter bit          P_ERR_EN = 1'b1
) (
   input logic            PCLK,
   input logic            PRESET,
   apb_mem_slave_if.slave bus
);

   localparam int          P_STRB   = P_DWIDTH / 8;
   localparam int          DEPTH    = int'(P_SIZE) / P_STRB;
   localparam int          AW       = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int          LB       = $clog2(P_STRB);
   localparam logic [15:0] MASK     = 16'(P_STRB - 1);
   localparam logic [3:0]  CNT_INIT = P_WAIT > 0 ? 4'(P_WAIT - 1) : 4'd0;

   state_t              state, state_nx;
   logic [15:0]         off, off_nx, ram_off, word;
   logic [3:0]          cnt, cnt_nx;
   logic                err, err_nx, wr, wr_nx;
   logic                setup, ready, we, unused;
   logic [P_DWIDTH-1:0] rdata;

   assign setup = bus.PSEL & ~bus.PENABLE;
   assign ready = state == ST_READY;

   // Next-state logic: latch the transfer at setup, count wait states, finish in one READY cycle.
   always_comb begin
      state_nx = state;
      off_nx   = off;
      err_nx   = err;
      wr_nx    = wr;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE:
            if (setup) begin
               off_nx   = bus.PADDR[15:0];
               err_nx   = addr_err(bus.PADDR[15:0], P_SIZE, MASK, P_ERR_EN);
               wr_nx    = bus.PWRITE;
               cnt_nx   = CNT_INIT;
               state_nx = P_WAIT == 0 ? ST_READY : ST_WAIT;
            end
         ST_WAIT:
            if (!bus.PSEL) begin
               state_nx = ST_IDLE;
               cnt_nx   = 4'd0;
            end else if (cnt == 4'd0) state_nx = ST_READY;
            else cnt_nx = cnt - 4'd1;
         ST_READY: state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // State register with synchronous reset that also aborts any transfer in flight.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state <= ST_IDLE;
         off   <= 16'd0;
         err   <= 1'b0;
         wr    <= 1'b0;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         off   <= off_nx;
         err   <= err_nx;
         wr    <= wr_nx;
         cnt   <= cnt_nx;
      end
   end

   // The RAM is addressed straight from the bus during IDLE so read data is ready by the first READY cycle.
   assign ram_off = state == ST_IDLE ? bus.PADDR[15:0] : off;
   assign word    = ram_off >> LB;
   assign we      = ready & wr & ~err & bus.PSEL & bus.PENABLE & ~PRESET;

   apb_mem_slave_ram #(
      .P_DWIDTH(P_DWIDTH),
      .P_DEPTH (DEPTH)
   ) u_ram (
      .PCLK (PCLK),
      .we   (we),
      .be   (bus.PSTRB),
      .addr (word[AW-1:0]),
      .wdata(bus.PWDATA),
      .rdata(rdata)
   );

   assign bus.PREADY  = ready;
   assign bus.PSLVERR = ready & err;
   assign bus.PRDATA  = ready & ~err & ~wr ? rdata : '0;

   assign unused = ^{bus.PPROT, bus.PADDR[31:16], word[15:AW]};

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: one APB initiator driving three memory slaves (0/2/5 wait states) against a byte-array model
module tb_apb_mem_slave;

   typedef struct {
      int          s;
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic        pclk = 1'b0, preset = 1'b1;
   logic [2:0]  psel = 3'b0, pprot = 3'b0;
   logic        penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = 32'd0, pwdata = 32'd0;
   logic [3:0]  pstrb = 4'd0;
   logic [2:0]  rdy, serr;
   logic [31:0] rd [3];
   int          ntest = 0, nfail = 0;
   int          wcnt [3];
   logic [7:0]  mem [3][16];
   exp_t        q [$];

   always #5 pclk = ~pclk;

   for (genvar g = 0; g < 3; g++) begin : g_slv
      apb_mem_slave_if #(.P_DWIDTH(32)) bus ();
      assign bus.PSEL    = psel[g];
      assign bus.PENABLE = penable;
      assign bus.PWRITE  = pwrite;
      assign bus.PADDR   = paddr;
      assign bus.PWDATA  = pwdata;
      assign bus.PSTRB   = pstrb;
      assign bus.PPROT   = pprot;
      apb_mem_slave #(
         .P_DWIDTH(32),
         .P_SIZE  (16'h0010),
         .P_WAIT  (g == 0 ? 0 : (g == 1 ? 2 : 5)),
         .P_ERR_EN(1'b1)
      ) dut (
         .PCLK  (pclk),
         .PRESET(preset),
         .bus   (bus)
      );
      assign rdy[g]  = bus.PREADY;
      assign serr[g] = bus.PSLVERR;
      assign rd[g]   = bus.PRDATA;
   end

   function automatic int waits(int s);
      return s == 0 ? 0 : (s == 1 ? 2 : 5);
   endfunction

   function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", n, act, exp);
      end
   endfunction

   // Monitor: on each falling edge, pop and check a completion, count wait states, and check idle outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge pclk);
         for (int s = 0; s < 3; s++) begin
            if (rdy[s]) begin
               if (!(psel[s] && penable) || q.size() == 0) begin
                  ntest++;
                  nfail++;
                  $display("FAIL unexpected_pready slave %0d: got PREADY=1, expected 0", s);
               end else begin
                  e = q.pop_front();
                  chk("slave_id", s, e.s);
                  chk("prdata", rd[s], e.d);
                  chk("pslverr", {31'd0, serr[s]}, {31'd0, e.e});
                  chk("wait_states", wcnt[s], waits(s));
               end
            end else begin
               wcnt[s] = (psel[s] && penable) ? wcnt[s] + 1 : 0;
               chk("idle_prdata", rd[s], 32'd0);
               chk("idle_pslverr", {31'd0, serr[s]}, 32'd0);
            end
         end
      end
   end

   task automatic gap(int n);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   // One complete APB transfer; the expected response is derived from the model and queued at issue.
   task automatic xfer(int s, logic [31:0] a, logic w, logic [31:0] d, logic [3:0] st);
      int   off = int'(a[15:0]);
      logic e = (off >= 16) || (off % 4 != 0);
      int   n = 0;
      exp_t x;
      x.s = s;
      x.e = e;
      x.d = 32'd0;
      if (!e && !w) for (int b = 0; b < 4; b++) x.d[8*b +: 8] = mem[s][off+b];
      if (!e && w) for (int b = 0; b < 4; b++) if (st[b]) mem[s][off+b] = d[8*b +: 8];
      q.push_back(x);
      psel    = 3'(1 << s);
      paddr   = a;
      pwrite  = w;
      pwdata  = d;
      pstrb   = st;
      pprot   = 3'($urandom);
      penable = 1'b0;
      @(posedge pclk);
      #1 penable = 1'b1;
      do begin
         @(negedge pclk);
         n++;
      end while (!rdy[s] && n < 40);
      if (!rdy[s]) begin
         ntest++;
         nfail++;
         $display("FAIL timeout slave %0d addr %h: got no PREADY in 40 cycles, expected PREADY=1", s, a);
         void'(q.pop_back());
      end
      @(posedge pclk);
      #1;
      psel    = 3'b0;
      penable = 1'b0;
   endtask

   initial begin
      int r, off;
      repeat (3) @(posedge pclk);
      #1 preset = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk("reset_pready", {31'd0, rdy[s]}, 32'd0);
         chk("reset_pslverr", {31'd0, serr[s]}, 32'd0);
         chk("reset_prdata", rd[s], 32'd0);
      end
      for (int s = 0; s < 3; s++)
         for (int w = 0; w < 4; w++) xfer(s, 32'(4 * w), 1'b1, $urandom, 4'hF);
      for (int s = 0; s < 3; s++) begin
         xfer(s, 32'h4, 1'b1, 32'h12345678, 4'hF);
         xfer(s, 32'h4, 1'b0, 32'h0, 4'hF);
         xfer(s, 32'hC, 1'b1, 32'hFFFFFFFF, 4'hF);
         xfer(s, 32'hC, 1'b1, 32'h00000000, 4'b0101);
         xfer(s, 32'hC, 1'b0, 32'h0, 4'hF);
         xfer(s, 32'h10, 1'b0, 32'h0, 4'hF);
         xfer(s, 32'h10, 1'b1, 32'hA5A5A5A5, 4'hF);
         xfer(s, 32'h2, 1'b1, 32'h5A5A5A5A, 4'hF);
         xfer(s, 32'h0, 1'b0, 32'h0, 4'hF);
         xfer(s, 32'h8, 1'b1, 32'hBADC0FFE, 4'h0);
         xfer(s, 32'h8, 1'b0, 32'h0, 4'hF);
      end
      psel    = 3'b100;
      paddr   = 32'h8;
      pwrite  = 1'b1;
      pwdata  = 32'hDEADBEEF;
      pstrb   = 4'hF;
      penable = 1'b0;
      gap(1);
      penable = 1'b1;
      gap(2);
      preset = 1'b1;
      gap(1);
      preset  = 1'b0;
      psel    = 3'b0;
      penable = 1'b0;
      chk("abort_pready", {31'd0, rdy[2]}, 32'd0);
      xfer(2, 32'h8, 1'b0, 32'h0, 4'hF);
      psel    = 3'b010;
      paddr   = 32'h4;
      pwrite  = 1'b1;
      pwdata  = 32'hCAFEF00D;
      gap(1);
      penable = 1'b1;
      gap(1);
      psel    = 3'b0;
      penable = 1'b0;
      gap(2);
      xfer(1, 32'h4, 1'b0, 32'h0, 4'hF);
      psel    = 3'b001;
      paddr   = 32'h0;
      pwrite  = 1'b1;
      pwdata  = 32'h0BADF00D;
      penable = 1'b1;
      gap(3);
      psel    = 3'b0;
      penable = 1'b0;
      gap(1);
      xfer(0, 32'h0, 1'b0, 32'h0, 4'hF);
      for (int i = 0; i < 300; i++) begin
         r   = int'($urandom_range(0, 9));
         off = r < 7 ? 4 * int'($urandom_range(0, 3)) :
               (r < 8 ? int'($urandom_range(16, 65535)) : int'($urandom_range(0, 15)));
         xfer(int'($urandom_range(0, 2)), {16'($urandom), 16'(off)}, 1'($urandom), $urandom, 4'($urandom));
         gap(int'($urandom_range(0, 2)));
      end
      gap(3);
      chk("queue_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected it to finish");
      $fatal(1);
   end

endmodule
